line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
Sequences the 10x20 board memory after a piece locks. It scans rows bottom-up for full lines and, for each full line, shifts every row above it down by one and clears the top row. It reports the number of lines cleared to the scoring logic. While busy, it owns the board read/write port; the top level muxes board_rx/ry/we/wx/wy/wdata from this block whenever busy=1, and from gamelogic otherwise.

Parameters:
W, 10, board width in cells (columns x = 0..W-1)
H, 20, board height in cells (rows y = 0..H-1; y=0 is the top row)
XW, 4, x coordinate width
YW, 5, y coordinate width
EARLY_EXIT, 1, when 1, a fully empty scanned row ends the pass (nothing can sit above it)

Ports:
CLOCK_50  in  1  system clock, all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request, issued by gamelogic after a piece is written into the board
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse at the end of the pass
lines_cleared  out  3  full rows removed in the last pass; valid from done until the next start; saturates at 7
board_rx  out  XW  read column address
board_ry  out  YW  read row address
board_rdata  in  1  cell value for the address presented on the previous cycle (1-cycle read latency)
board_we  out  1  write enable
board_wx  out  XW  write column
board_wy  out  YW  write row
board_wdata  out  1  write data

Behaviour:
- Reset values (applied at the clock edge while reset=1): state=IDLE, busy=0, done=0, lines_cleared=0, board_we=0, all addresses 0, board_wdata=0. Reset mid-pass abandons the pass immediately; a partially shifted board is acceptable because a game reset also clears the board.
- All outputs are registered.
- IDLE: board_we=0. If start=1, go to SCAN with y=H-1, x=0, full=1, any=0, count=0. start while busy is ignored, not queued.
- SCAN (W cycles): present (x, y) on the read port, x=0..W-1. Each returned bit is ANDed into full and ORed into any, one cycle after it was issued.
- CHECK (1 cycle): fold in the last bit, then decide:
  - If full: count = min(count+1, 7). If y>0, go to SHIFT_RD with r=y, x=0. If y=0, go to CLEAR_TOP.
  - If EARLY_EXIT and !any: go to DONE.
  - If y=0: go to DONE.
  - Otherwise: y=y-1, go to SCAN.
- SHIFT_RD (1 cycle): read (x, r-1).
- SHIFT_WR (1 cycle): write board_rdata to (x, r) with board_we=1. Then x++. When x reaches W-1, set x=0 and r--. When r reaches 0, go to CLEAR_TOP. Cost is 2 cycles per cell.
- CLEAR_TOP (W cycles): write 0 to (x, 0) for x=0..W-1. Then go to SCAN at the same y, because a new row has dropped into it. y is not decremented.
- DONE (1 cycle): done=1, lines_cleared=count, busy=1. Next state is IDLE with busy=0.
- board_we=1 only in SHIFT_WR and CLEAR_TOP. The read address is don't-care in write states but is driven to 0.
- Worst-case pass (4 lines at rows 19..16) completes in under 2000 cycles, which is well inside one gravity tick.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_W=10, BOARD_H=20, X_W=4, Y_W=5, also used by gamelogic and the renderer
  - the state encoding localparams for this FSM
- No sub-module; a single FSM with x/y/r counters and the full/any accumulators.
- The port mux (select on busy) stays in the top level, not in this block.

Test Plan:
- Empty board, start at cycle 0 → SCAN on cycles 1-10, CHECK on 11, done=1 on cycle 12 with lines_cleared=0. No board_we is ever asserted.
- Row 19 full, row 18 = 1000000001b, rest empty → 380 shift cycles plus 10 clear cycles, rescan rows 19 and 18. Expect done with lines_cleared=1, row 19 = 1000000001b, rows 0-18 all zero.
- Rows 19, 18, 17, 16 full, row 15 has one cell at x=3 → lines_cleared=4, row 19 has only x=3 set, all other cells zero. Verify done arrives within 2000 cycles.
- Rows 19 and 17 full, row 18 has x=0 only → lines_cleared=2, row 19 has x=0 only. This checks the same-row rescan after a shift.
- Only row 0 full (EARLY_EXIT=0) → CLEAR_TOP with no shift. Expect lines_cleared=1 and the board fully empty.
- Assert reset 50 cycles into a shift → next edge gives busy=0, board_we=0, done=0. A fresh start then runs a normal pass. A start pulse while busy has no effect on count or timing.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry and the line-clear FSM state encoding, used by
// gamelogic, the renderer and line_clear_ctrl.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int X_W     = 4;
  localparam int Y_W     = 5;

  localparam logic [2:0] LINES_MAX = 3'd7;

  typedef enum logic [2:0] {
    LC_IDLE      = 3'd0,
    LC_SCAN      = 3'd1,
    LC_CHECK     = 3'd2,
    LC_SHIFT_RD  = 3'd3,
    LC_SHIFT_WR  = 3'd4,
    LC_CLEAR_TOP = 3'd5,
    LC_DONE      = 3'd6
  } lc_state_e;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    if (v == LINES_MAX) begin
      return v;
    end else begin
      return v + 3'd1;
    end
  endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// Post-lock line clear sequencer: scans rows bottom-up, drops everything above
// each full row by one, blanks row 0 and reports how many rows were removed.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int W          = BOARD_W,
  parameter int H          = BOARD_H,
  parameter int XW         = X_W,
  parameter int YW         = Y_W,
  parameter int EARLY_EXIT = 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    lines_cleared,
  output logic [XW-1:0] board_rx,
  output logic [YW-1:0] board_ry,
  input  logic          board_rdata,
  output logic          board_we,
  output logic [XW-1:0] board_wx,
  output logic [YW-1:0] board_wy,
  output logic          board_wdata
);

  localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
  localparam logic [YW-1:0] Y_BOTTOM = YW'(H - 1);

  lc_state_e     state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] r_q, r_d;
  logic          full_q, full_d;
  logic          any_q, any_d;
  logic [2:0]    count_q, count_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    lines_q, lines_d;
  logic [XW-1:0] rx_q, rx_d;
  logic [YW-1:0] ry_q, ry_d;
  logic          we_q, we_d;
  logic [XW-1:0] wx_q, wx_d;
  logic [YW-1:0] wy_q, wy_d;
  logic          wdata_q, wdata_d;

  logic          full_in;
  logic          any_in;

  assign full_in = full_q & board_rdata;
  assign any_in  = any_q | board_rdata;

  // Next-state logic for the FSM and its row/column counters and accumulators.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    full_d  = full_q;
    any_d   = any_q;
    count_d = count_q;

    case (state_q)
      LC_IDLE: begin
        if (start) begin
          state_d = LC_SCAN;
          y_d     = Y_BOTTOM;
          x_d     = '0;
          full_d  = 1'b1;
          any_d   = 1'b0;
          count_d = 3'd0;
        end else begin
          state_d = LC_IDLE;
        end
      end

      LC_SCAN: begin
        // rdata lags the address by one cycle, so the x=0 slot holds no cell yet.
        if (x_q == '0) begin
          full_d = 1'b1;
          any_d  = 1'b0;
        end else begin
          full_d = full_in;
          any_d  = any_in;
        end
        if (x_q == X_LAST) begin
          state_d = LC_CHECK;
        end else begin
          x_d = x_q + XW'(1);
        end
      end

      LC_CHECK: begin
        full_d = full_in;
        any_d  = any_in;
        x_d    = '0;
        if (full_in) begin
          count_d = sat_inc3(count_q);
          if (y_q != '0) begin
            state_d = LC_SHIFT_RD;
            r_d     = y_q;
          end else begin
            state_d = LC_CLEAR_TOP;
          end
        end else if ((EARLY_EXIT != 0) && !any_in) begin
          state_d = LC_DONE;
        end else if (y_q == '0) begin
          state_d = LC_DONE;
        end else begin
          y_d     = y_q - YW'(1);
          state_d = LC_SCAN;
        end
      end

      LC_SHIFT_RD: begin
        state_d = LC_SHIFT_WR;
      end

      LC_SHIFT_WR: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          r_d = r_q - YW'(1);
          if (r_q == YW'(1)) begin
            state_d = LC_CLEAR_TOP;
          end else begin
            state_d = LC_SHIFT_RD;
          end
        end else begin
          x_d     = x_q + XW'(1);
          state_d = LC_SHIFT_RD;
        end
      end

      LC_CLEAR_TOP: begin
        // A new row has dropped into y, so rescan it without moving up.
        if (x_q == X_LAST) begin
          x_d     = '0;
          state_d = LC_SCAN;
        end else begin
          x_d = x_q + XW'(1);
        end
      end

      LC_DONE: begin
        state_d = LC_IDLE;
      end

      default: begin
        state_d = LC_IDLE;
      end
    endcase
  end

  // Output register inputs: status and read port follow the next state.
  always_comb begin
    busy_d  = (state_d != LC_IDLE);
    done_d  = (state_d == LC_DONE);
    lines_d = lines_q;
    rx_d    = '0;
    ry_d    = '0;

    if (state_d == LC_DONE) begin
      lines_d = count_d;
    end else begin
      lines_d = lines_q;
    end

    case (state_d)
      LC_SCAN: begin
        rx_d = x_d;
        ry_d = y_d;
      end
      LC_SHIFT_RD: begin
        rx_d = x_d;
        ry_d = r_d - YW'(1);
      end
      default: begin
        rx_d = '0;
        ry_d = '0;
      end
    endcase
  end

  // Write port registers capture this cycle's write so wdata can be a flop
  // holding board_rdata; each write reaches the board one cycle later.
  always_comb begin
    we_d    = 1'b0;
    wx_d    = '0;
    wy_d    = '0;
    wdata_d = 1'b0;

    case (state_q)
      LC_SHIFT_WR: begin
        we_d    = 1'b1;
        wx_d    = x_q;
        wy_d    = r_q;
        wdata_d = board_rdata;
      end
      LC_CLEAR_TOP: begin
        we_d    = 1'b1;
        wx_d    = x_q;
        wy_d    = '0;
        wdata_d = 1'b0;
      end
      default: begin
        we_d    = 1'b0;
        wx_d    = '0;
        wy_d    = '0;
        wdata_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= LC_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      full_q  <= 1'b0;
      any_q   <= 1'b0;
      count_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lines_q <= 3'd0;
      rx_q    <= '0;
      ry_q    <= '0;
      we_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      full_q  <= full_d;
      any_q   <= any_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lines_q <= lines_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      we_q    <= we_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign board_rx      = rx_q;
  assign board_ry      = ry_q;
  assign board_we      = we_q;
  assign board_wx      = wx_q;
  assign board_wy      = wy_q;
  assign board_wdata   = wdata_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: two instances (early exit on/off), each
// with a 1-cycle-latency board model; expected passes are queued at start.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int W = BOARD_W;
  localparam int H = BOARD_H;

  typedef logic [H-1:0][W-1:0] board_t;
  typedef struct packed {
    logic [2:0]  lines;
    board_t      board;
    logic [31:0] c0;
    logic [31:0] lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0, start1;
  logic       busy0, done0, rdata0, we0, wdata0;
  logic       busy1, done1, rdata1, we1, wdata1;
  logic [2:0] lines0, lines1;
  logic [3:0] rx0, wx0, rx1, wx1;
  logic [4:0] ry0, wy0, ry1, wy1;

  logic [W-1:0] mem0 [H];
  logic [W-1:0] mem1 [H];
  board_t       init_b;
  logic         load0, load1;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;

  line_clear_ctrl #(.EARLY_EXIT(1)) u_dut0 (
    .CLOCK_50(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .lines_cleared(lines0), .board_rx(rx0), .board_ry(ry0), .board_rdata(rdata0),
    .board_we(we0), .board_wx(wx0), .board_wy(wy0), .board_wdata(wdata0)
  );

  line_clear_ctrl #(.EARLY_EXIT(0)) u_dut1 (
    .CLOCK_50(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .lines_cleared(lines1), .board_rx(rx1), .board_ry(ry1), .board_rdata(rdata1),
    .board_we(we1), .board_wx(wx1), .board_wy(wy1), .board_wdata(wdata1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load0) begin
      for (int i = 0; i < H; i++) mem0[i] <= init_b[i];
    end else if (we0) begin
      mem0[wy0][wx0] <= wdata0;
    end
    rdata0 <= mem0[ry0][rx0];
  end

  always @(posedge clk) begin
    if (load1) begin
      for (int j = 0; j < H; j++) mem1[j] <= init_b[j];
    end else if (we1) begin
      mem1[wy1][wx1] <= wdata1;
    end
    rdata1 <= mem1[ry1][rx1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic board_t mem_board(input int idx);
    board_t b;
    for (int k = 0; k < H; k++) b[k] = (idx == 0) ? mem0[k] : mem1[k];
    return b;
  endfunction

  task automatic score(input int idx, input logic [2:0] lines, input exp_t e);
    board_t cur;
    cur = mem_board(idx);
    check($sformatf("dut%0d_lines_cleared", idx), 32'(lines), 32'(e.lines));
    n_checks++;
    if (cur !== e.board) begin
      n_fail++;
      $display("FAIL dut%0d_board: got %h expected %h", idx, cur, e.board);
    end
    check($sformatf("dut%0d_done_latency", idx), cyc - e.c0, e.lat);
  endtask

  // Monitors: every done pulse consumes one expected pass.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 32'(done0), 32'd0);
      end else begin
        e0 = q0.pop_front();
        score(0, lines0, e0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        score(1, lines1, e1);
      end
    end
  end

  task automatic load_board(input int idx, input board_t b);
    @(negedge clk);
    init_b = b;
    if (idx == 0) load0 = 1'b1; else load1 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic pulse_start(input int idx);
    if (idx == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_drain(input int idx);
    for (int t = 0; t < 5000; t++) begin
      if ((idx == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if ((idx == 0 ? q0.size() : q1.size()) != 0) begin
      check($sformatf("dut%0d_done_timeout", idx), 32'd0, 32'd1);
      if (idx == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic run_pass(input int idx, input board_t b, input logic [2:0] el,
                          input board_t eb, input int lat, input bit poke);
    exp_t e;
    load_board(idx, b);
    @(negedge clk);
    e.lines = el;
    e.board = eb;
    e.c0    = cyc;
    e.lat   = 32'(lat);
    if (idx == 0) q0.push_back(e); else q1.push_back(e);
    pulse_start(idx);
    if (poke) begin
      repeat (5) @(negedge clk);
      pulse_start(idx);
    end
    wait_drain(idx);
    repeat (2) @(negedge clk);
  endtask

  board_t b, eb;

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    load0  = 1'b0;
    load1  = 1'b0;
    init_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy0", 32'(busy0), 32'd0);
    check("reset_done0", 32'(done0), 32'd0);
    check("reset_lines0", 32'(lines0), 32'd0);
    check("reset_we0", 32'(we0), 32'd0);
    check("reset_busy1", 32'(busy1), 32'd0);
    reset = 1'b0;

    // Empty board: done on cycle 12, nothing cleared.
    b = '0;
    run_pass(0, b, 3'd0, b, 12, 1'b0);

    // Row 19 with one hole: not full, rows above empty.
    b = '0; b[19] = 10'b1111011111;
    run_pass(0, b, 3'd0, b, 23, 1'b0);

    // Row 19 full, row 18 = 1000000001b.
    b = '0; b[19] = 10'h3FF; b[18] = 10'b1000000001;
    eb = '0; eb[19] = 10'b1000000001;
    run_pass(0, b, 3'd1, eb, 424, 1'b0);

    // Rows 19..16 full, row 15 has x=3.
    b = '0; b[19] = 10'h3FF; b[18] = 10'h3FF; b[17] = 10'h3FF; b[16] = 10'h3FF;
    b[15] = 10'b0000001000;
    eb = '0; eb[19] = 10'b0000001000;
    run_pass(0, b, 3'd4, eb, 1627, 1'b0);

    // Rows 19 and 17 full, row 18 x=0: same-row rescan after a shift.
    b = '0; b[19] = 10'h3FF; b[18] = 10'b0000000001; b[17] = 10'h3FF;
    eb = '0; eb[19] = 10'b0000000001;
    run_pass(0, b, 3'd2, eb, 805, 1'b0);

    // Eight full rows: count saturates at 7.
    b = '0;
    for (int y = 12; y < 20; y++) b[y] = 10'h3FF;
    eb = '0;
    run_pass(0, b, 3'd7, eb, 3220, 1'b0);

    // Only row 0 full, early exit disabled: clear top without a shift.
    b = '0; b[0] = 10'h3FF;
    eb = '0;
    run_pass(1, b, 3'd1, eb, 242, 1'b0);

    // Empty board, early exit disabled: all 20 rows scanned.
    b = '0;
    run_pass(1, b, 3'd0, b, 221, 1'b0);

    // Reset mid-shift abandons the pass.
    b = '0; b[19] = 10'h3FF; b[18] = 10'b1000000001;
    load_board(0, b);
    @(negedge clk);
    pulse_start(0);
    repeat (61) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midpass_reset_busy", 32'(busy0), 32'd0);
    check("midpass_reset_we", 32'(we0), 32'd0);
    check("midpass_reset_done", 32'(done0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fresh pass after reset, with a start pulse while busy.
    eb = '0; eb[19] = 10'b1000000001;
    run_pass(0, b, 3'd1, eb, 424, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
